// File: rtl/spb_pkg.sv
// Shared types, constants and helpers for the SPB frame-sync detector.
package spb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PD_SRCH = 2'd1,
    BD_SRCH = 2'd2,
    LOCKED  = 2'd3
  } sync_state_t;

  localparam logic [12:0] BARKER13 = 13'h1F35;

  // Callers sign-extend into 32 bits, so the most negative sample has a representable magnitude.
  function automatic logic [31:0] mag_abs(input logic signed [31:0] x);
    return x[31] ? 32'(-x) : 32'(x);
  endfunction

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/spb_energy_avg.sv
// Block-averaged |I|+|Q| energy detector with hi/lo hysteresis, producing SD_flag.
module spb_energy_avg
  import spb_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int MAX_WIN_LOG2 = 8,
  parameter int WIN_W        = $clog2(MAX_WIN_LOG2 + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_enable,
  input  logic signed [WIDTH-1:0] i_in,
  input  logic signed [WIDTH-1:0] q_in,
  input  logic                    smp_valid,
  input  logic [WIDTH:0]          thr_hi,
  input  logic [WIDTH:0]          thr_lo,
  input  logic [WIN_W-1:0]        win_log2,
  output logic                    sd_flag
);

  localparam int ACC_W = WIDTH + 1 + MAX_WIN_LOG2;
  localparam int CNT_W = MAX_WIN_LOG2 + 1;

  logic [ACC_W-1:0] acc_q, acc_d, acc_sum, avg;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [WIN_W-1:0] win_q, win_d, win_eff;
  logic [WIDTH:0]   mag;
  logic             sd_q, sd_d;
  logic             blk_end;

  always_comb begin
    mag     = (WIDTH + 1)'(mag_abs(32'(i_in)) + mag_abs(32'(q_in)));
    // The window is sampled only on the first sample of a block, so a config change waits for the boundary.
    if (cnt_q == '0)
      win_eff = (win_log2 > WIN_W'(MAX_WIN_LOG2)) ? WIN_W'(MAX_WIN_LOG2) : win_log2;
    else
      win_eff = win_q;
    acc_sum = acc_q + ACC_W'(mag);
    cnt_inc = cnt_q + CNT_W'(1);
    blk_end = (cnt_inc == (CNT_W'(1) << win_eff));
    avg     = acc_sum >> win_eff;

    acc_d = acc_q;
    cnt_d = cnt_q;
    win_d = win_q;
    sd_d  = sd_q;
    if (clk_enable && smp_valid) begin
      win_d = win_eff;
      if (blk_end) begin
        acc_d = '0;
        cnt_d = '0;
        if (avg >= ACC_W'(thr_hi))     sd_d = 1'b1;
        else if (avg < ACC_W'(thr_lo)) sd_d = 1'b0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      win_q <= '0;
      sd_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      win_q <= win_d;
      sd_q  <= sd_d;
    end
  end

  assign sd_flag = sd_q;

endmodule

// File: rtl/spb_sync_detector.sv
// SPB frame-sync detector: energy gate, preamble run counter and Barker correlator under one FSM.
// Defining SPB_TIMEOUT_EN adds a symbol watchdog to the PD_SRCH and BD_SRCH states.
module spb_sync_detector
  import spb_pkg::*;
#(
  parameter int                    WIDTH        = 16,
  parameter int                    MAX_WIN_LOG2 = 8,
  parameter int                    PD_CNT_W     = 8,
  parameter int                    BARKER_LEN   = 13,
  parameter logic [BARKER_LEN-1:0] BARKER_CODE  = BARKER13,
  parameter int                    TIMEOUT_SYMS = 1024
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   clk_enable,
  input  logic signed [WIDTH-1:0]                I_in,
  input  logic signed [WIDTH-1:0]                Q_in,
  input  logic                                   smp_valid,
  input  logic                                   sym_valid,
  input  logic [1:0]                             sym_bits,
  input  logic                                   BPSK,
  input  logic [WIDTH:0]                         cfg_sd_thr_hi,
  input  logic [WIDTH:0]                         cfg_sd_thr_lo,
  input  logic [$clog2(MAX_WIN_LOG2+1)-1:0]      cfg_sd_win_log2,
  input  logic [PD_CNT_W-1:0]                    cfg_pd_len,
  input  logic [4:0]                             cfg_bd_thr,
  input  logic                                   frame_done,
  output logic                                   SD_flag,
  output logic                                   PD_flag,
  output logic                                   BD_flag,
  output logic                                   BD_sgn,
  output logic [1:0]                             sync_state
);

  localparam int FILL_W = $clog2(BARKER_LEN + 1);

  // smp_valid, sym_valid and frame_done are single-cycle qualifiers with no back-pressure;
  // each is consumed on the clock where it is high and clk_enable is high.
  sync_state_t           state_q, state_d;
  logic                  sd_flag;
  logic                  pd_q, pd_d, bd_q, bd_d, sgn_q, sgn_d;
  logic                  sym_adv, trans, pd_reached;
  logic [1:0]            prev_q, prev_d;
  logic [PD_CNT_W-1:0]   pd_cnt_q, pd_cnt_d, pd_cnt_nx;
  logic [BARKER_LEN-1:0] shreg_q, shreg_d, shreg_nx;
  logic [FILL_W-1:0]     fill_q, fill_d, fill_nx;
  logic [5:0]            mism2, corr_abs;
  logic                  corr_neg, bd_hit, timeout;

  spb_energy_avg #(
    .WIDTH        (WIDTH),
    .MAX_WIN_LOG2 (MAX_WIN_LOG2)
  ) u_energy (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_enable (clk_enable),
    .i_in       (I_in),
    .q_in       (Q_in),
    .smp_valid  (smp_valid),
    .thr_hi     (cfg_sd_thr_hi),
    .thr_lo     (cfg_sd_thr_lo),
    .win_log2   (cfg_sd_win_log2),
    .sd_flag    (sd_flag)
  );

  always_comb begin
    sym_adv = clk_enable && sym_valid;
    // QPSK only counts a full 180-degree flip as a preamble transition.
    trans   = BPSK ? (sym_bits[0] != prev_q[0]) : (sym_bits == ~prev_q);

    pd_cnt_nx = pd_cnt_q;
    if (sym_adv) begin
      if (!trans)                pd_cnt_nx = '0;
      else if (pd_cnt_q != '1)   pd_cnt_nx = pd_cnt_q + PD_CNT_W'(1);
    end
    pd_reached = (pd_cnt_nx >= cfg_pd_len);

    shreg_nx = {shreg_q[BARKER_LEN-2:0], sym_bits[0]};
    fill_nx  = (fill_q == FILL_W'(BARKER_LEN)) ? fill_q : fill_q + FILL_W'(1);
    mism2    = {popcount(16'(shreg_nx ^ BARKER_CODE)), 1'b0};
    if (mism2 > 6'(BARKER_LEN)) begin
      corr_neg = 1'b1;
      corr_abs = mism2 - 6'(BARKER_LEN);
    end else begin
      corr_neg = 1'b0;
      corr_abs = 6'(BARKER_LEN) - mism2;
    end
    bd_hit = sym_adv && (state_q == BD_SRCH) && (fill_nx == FILL_W'(BARKER_LEN)) &&
             (corr_abs >= {1'b0, cfg_bd_thr});
  end

`ifdef SPB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_SYMS + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d, to_nx;
  logic            searching;

  always_comb begin
    searching = (state_q == PD_SRCH) || (state_q == BD_SRCH);
    to_nx     = (searching && sym_adv) ? to_cnt_q + TO_W'(1) : to_cnt_q;
    timeout   = searching && sym_adv && (to_nx >= TO_W'(TIMEOUT_SYMS));
    to_cnt_d  = (state_d != state_q) ? '0 : to_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // Loss of energy outranks every other event, including a same-cycle hit or frame_done.
  always_comb begin
    state_d = state_q;
    pd_d    = pd_q;
    bd_d    = bd_q;
    sgn_d   = sgn_q;
    if (clk_enable) begin
      if (!sd_flag || timeout) begin
        state_d = IDLE;
        pd_d    = 1'b0;
        bd_d    = 1'b0;
        sgn_d   = 1'b0;
      end else begin
        unique case (state_q)
          IDLE:    state_d = PD_SRCH;
          PD_SRCH: if (pd_reached) begin
                     state_d = BD_SRCH;
                     pd_d    = 1'b1;
                   end
          BD_SRCH: if (bd_hit) begin
                     state_d = LOCKED;
                     bd_d    = 1'b1;
                     sgn_d   = corr_neg;
                   end
          LOCKED:  if (frame_done) begin
                     state_d = IDLE;
                     pd_d    = 1'b0;
                     bd_d    = 1'b0;
                     sgn_d   = 1'b0;
                   end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    prev_d   = sym_adv ? sym_bits : prev_q;
    pd_cnt_d = (state_q == PD_SRCH && state_d == PD_SRCH) ? pd_cnt_nx : '0;
    shreg_d  = shreg_q;
    fill_d   = fill_q;
    // Clearing on entry stops preamble symbols from contributing to the correlation.
    if (state_d == BD_SRCH && state_q != BD_SRCH) begin
      shreg_d = '0;
      fill_d  = '0;
    end else if (sym_adv && state_q == BD_SRCH) begin
      shreg_d = shreg_nx;
      fill_d  = fill_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pd_q     <= 1'b0;
      bd_q     <= 1'b0;
      sgn_q    <= 1'b0;
      prev_q   <= '0;
      pd_cnt_q <= '0;
      shreg_q  <= '0;
      fill_q   <= '0;
    end else begin
      state_q  <= state_d;
      pd_q     <= pd_d;
      bd_q     <= bd_d;
      sgn_q    <= sgn_d;
      prev_q   <= prev_d;
      pd_cnt_q <= pd_cnt_d;
      shreg_q  <= shreg_d;
      fill_q   <= fill_d;
    end
  end

  assign SD_flag    = sd_flag;
  assign PD_flag    = pd_q;
  assign BD_flag    = bd_q;
  assign BD_sgn     = sgn_q;
  assign sync_state = state_q;

endmodule

// File: tb/tb_spb_sync_detector.sv
// Directed bench for spb_sync_detector with a behavioural reference model checked every cycle.
module tb_spb_sync_detector;

  localparam int          WIDTH   = 16;
  localparam int          TO_SYMS = 16;
  localparam logic [12:0] TB_CODE = 13'h1F35;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    clk_enable;
  logic signed [WIDTH-1:0] I_in, Q_in;
  logic                    smp_valid, sym_valid, BPSK, frame_done;
  logic [1:0]              sym_bits;
  logic [WIDTH:0]          cfg_sd_thr_hi, cfg_sd_thr_lo;
  logic [3:0]              cfg_sd_win_log2;
  logic [7:0]              cfg_pd_len;
  logic [4:0]              cfg_bd_thr;
  logic                    SD_flag, PD_flag, BD_flag, BD_sgn;
  logic [1:0]              sync_state;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  spb_sync_detector #(.TIMEOUT_SYMS(TO_SYMS)) dut (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
    .I_in(I_in), .Q_in(Q_in), .smp_valid(smp_valid),
    .sym_valid(sym_valid), .sym_bits(sym_bits), .BPSK(BPSK),
    .cfg_sd_thr_hi(cfg_sd_thr_hi), .cfg_sd_thr_lo(cfg_sd_thr_lo),
    .cfg_sd_win_log2(cfg_sd_win_log2), .cfg_pd_len(cfg_pd_len),
    .cfg_bd_thr(cfg_bd_thr), .frame_done(frame_done),
    .SD_flag(SD_flag), .PD_flag(PD_flag), .BD_flag(BD_flag),
    .BD_sgn(BD_sgn), .sync_state(sync_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [1:0] m_state = 2'd0, nstate;
  logic       m_sd = 1'b0, m_pd = 1'b0, m_bd = 1'b0, m_sgn = 1'b0;
  longint     m_sum = 0, avg;
  int         m_n = 0, m_win = 0, m_run = 0, m_tsyms = 0, corr, mag;
  logic [1:0] m_prev = 2'b00;
  bit         trans, hit, to_hit;
  int         bq[$];

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 2'd0; m_sd = 0; m_pd = 0; m_bd = 0; m_sgn = 0;
      m_sum = 0; m_n = 0; m_win = 0; m_run = 0; m_tsyms = 0; m_prev = 2'b00;
      bq.delete();
    end else if (clk_enable) begin
      hit = 0; to_hit = 0; corr = 0;
      if (sym_valid) begin
        trans  = BPSK ? (sym_bits[0] != m_prev[0]) : (sym_bits[0] != m_prev[0] && sym_bits[1] != m_prev[1]);
        m_prev = sym_bits;
        if (m_state == 2'd1) m_run = trans ? ((m_run < 255) ? m_run + 1 : 255) : 0;
        if (m_state == 2'd2) begin
          bq.push_back(int'(sym_bits[0]));
          if (bq.size() > 13) void'(bq.pop_front());
          if (bq.size() == 13) begin
            for (int i = 0; i < 13; i++) corr += (bq[i] == int'(TB_CODE[12-i])) ? 1 : -1;
            hit = (iabs(corr) >= int'(cfg_bd_thr));
          end
        end
`ifdef SPB_TIMEOUT_EN
        if (m_state == 2'd1 || m_state == 2'd2) begin
          m_tsyms++;
          if (m_tsyms >= TO_SYMS) to_hit = 1;
        end
`endif
      end
      nstate = m_state;
      if (!m_sd || to_hit) begin
        nstate = 2'd0; m_pd = 0; m_bd = 0; m_sgn = 0;
      end else begin
        case (m_state)
          2'd0: nstate = 2'd1;
          2'd1: if (m_run >= int'(cfg_pd_len)) begin nstate = 2'd2; m_pd = 1; end
          2'd2: if (hit) begin nstate = 2'd3; m_bd = 1; m_sgn = (corr < 0); end
          default: if (frame_done) begin nstate = 2'd0; m_pd = 0; m_bd = 0; m_sgn = 0; end
        endcase
      end
      if (nstate != m_state) begin
        m_run = 0; m_tsyms = 0; bq.delete();
      end
      m_state = nstate;
      if (smp_valid) begin
        if (m_n == 0) m_win = (cfg_sd_win_log2 > 8) ? 8 : int'(cfg_sd_win_log2);
        mag   = iabs(int'(I_in)) + iabs(int'(Q_in));
        m_sum += mag;
        m_n++;
        if (m_n == (1 << m_win)) begin
          avg = m_sum >>> m_win;
          if (avg >= longint'(cfg_sd_thr_hi))     m_sd = 1;
          else if (avg < longint'(cfg_sd_thr_lo)) m_sd = 0;
          m_sum = 0; m_n = 0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (cmp_en)
      check("cycle_model", {27'd0, sync_state, SD_flag, PD_flag, BD_flag, BD_sgn},
            {27'd0, m_state, m_sd, m_pd, m_bd, m_sgn});
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_smp(input int i, input int q);
    I_in = 16'(i); Q_in = 16'(q); smp_valid = 1'b1;
    @(posedge clk); #1;
    smp_valid = 1'b0;
  endtask

  task automatic send_block(input int i, input int q, input int n);
    for (int k = 0; k < n; k++) send_smp(i, q);
  endtask

  task automatic send_sym(input logic [1:0] b);
    sym_bits = b; sym_valid = 1'b1;
    @(posedge clk); #1;
    sym_valid = 1'b0;
  endtask

  task automatic send_code(input logic [12:0] c, input int n);
    for (int k = 0; k < n; k++) send_sym({1'b0, c[12-k]});
  endtask

  task automatic pulse_done();
    frame_done = 1'b1;
    @(posedge clk); #1;
    frame_done = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [12:0] cw;
  logic [1:0]  qseq [8];

  initial begin
    rst_n = 1'b0; clk_enable = 1'b1; I_in = '0; Q_in = '0; smp_valid = 0;
    sym_valid = 0; sym_bits = 2'b00; BPSK = 1'b1; frame_done = 0;
    cfg_sd_thr_hi = 17'd1000; cfg_sd_thr_lo = 17'd600; cfg_sd_win_log2 = 4'd4;
    cfg_pd_len = 8'd8; cfg_bd_thr = 5'd13;
    repeat (3) @(posedge clk);
    #1 cmp_en = 1'b1;
    check("reset_outputs", {27'd0, sync_state, SD_flag, PD_flag, BD_flag, BD_sgn}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // hysteresis, window 16 samples
    send_block(600, -600, 15);
    check("sd_before_first_end", SD_flag, 0);
    send_smp(600, -600);
    check("sd_set_avg1200", SD_flag, 1);
    send_block(500, 300, 16);
    check("sd_hold_avg800", SD_flag, 1);
    send_block(250, -250, 15);
    check("sd_before_low_end", SD_flag, 1);
    send_smp(250, -250);
    check("sd_clear_avg500", SD_flag, 0);
    send_block(1200, 0, 16);
    idle(2);
    check("pd_srch_entry", sync_state, 1);

    // frozen symbols must not count
    clk_enable = 1'b0;
    send_sym(2'b01); send_sym(2'b00);
    clk_enable = 1'b1;

    // BPSK preamble
    for (int k = 0; k < 7; k++) send_sym({1'b0, ~k[0]});
    send_sym(2'b01);
    check("pd_after_repeat", PD_flag, 0);
    for (int k = 0; k < 7; k++) send_sym({1'b0, k[0]});
    check("pd_after_7", PD_flag, 0);
    send_sym(2'b01);
    check("pd_after_8", PD_flag, 1);
    check("bd_srch_entry", sync_state, 2);

    // exact Barker
    cw = TB_CODE;
    send_code(cw, 12);
    check("bd_before_13", BD_flag, 0);
    send_sym({1'b0, cw[0]});
    check("bd_exact", {BD_flag, BD_sgn, sync_state}, {28'd0, 4'b1011});
    pulse_done();
    check("release", {PD_flag, BD_flag, BD_sgn, sync_state}, 32'd0);

    // cfg_pd_len = 0, frame_done ignored outside LOCKED, inverted code
    cfg_pd_len = 8'd0;
    idle(3);
    check("pd_len0_immediate", {PD_flag, sync_state}, {29'd0, 3'b110});
    pulse_done();
    check("done_ignored", sync_state, 2);
    cw = ~TB_CODE;
    send_code(cw, 13);
    check("bd_inverted", {BD_flag, BD_sgn, sync_state}, {28'd0, 4'b1111});
    pulse_done();

    // one bit error: misses at thr 13, hits at thr 11
    idle(3);
    cw = TB_CODE ^ 13'h0020;
    send_code(cw, 13);
    check("bd_err_thr13", {BD_flag, sync_state}, {29'd0, 3'b010});
    send_block(100, 100, 16);
    idle(1);
    check("sd_drop_idle", sync_state, 0);
    send_block(1200, 0, 16);
    idle(3);
    cfg_bd_thr = 5'd11;
    send_code(cw, 13);
    check("bd_err_thr11", {BD_flag, BD_sgn, sync_state}, {28'd0, 4'b1011});
    pulse_done();

    // SD drop seen together with the final Barker symbol
    cfg_bd_thr = 5'd13;
    idle(3);
    cw = TB_CODE;
    send_code(cw, 12);
    send_block(100, 100, 16);
    send_sym({1'b0, cw[0]});
    check("sd_priority", {BD_flag, sync_state}, 32'd0);

    // QPSK preamble, prev bits = 2'b01
    cfg_pd_len = 8'd4;
    BPSK = 1'b0;
    send_block(1200, 0, 16);
    idle(2);
    qseq = '{2'b10, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11};
    for (int k = 0; k < 4; k++) send_sym(qseq[k]);
    check("qpsk_partial_flip", PD_flag, 0);
    for (int k = 4; k < 7; k++) send_sym(qseq[k]);
    check("qpsk_after_3", PD_flag, 0);
    send_sym(qseq[7]);
    check("qpsk_pd", {PD_flag, sync_state}, {29'd0, 3'b110});

    // asynchronous reset while locked
    cw = TB_CODE;
    send_code(cw, 13);
    check("locked_again", sync_state, 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {27'd0, sync_state, SD_flag, PD_flag, BD_flag, BD_sgn}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    BPSK = 1'b1;
    cfg_pd_len = 8'd8;
    send_block(1200, 0, 16);
    idle(2);
    check("search_after_reset", sync_state, 1);
    for (int k = 0; k < TO_SYMS - 1; k++) send_sym(2'b00);
    check("search_before_limit", sync_state, 1);
    send_sym(2'b00);
`ifdef SPB_TIMEOUT_EN
    check("timeout_idle", {PD_flag, sync_state}, 32'd0);
    idle(1);
    check("timeout_reenter", sync_state, 1);
`else
    check("no_timeout", sync_state, 1);
    send_block(1200, 0, 16);
    check("still_searching", sync_state, 1);
`endif
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
